// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-flop synchronizer plus per-button debounce FSM producing level and press/release strobes.
// Optional macro BTN_AUTOREPEAT_EN adds hold-to-repeat press strobes while a button stays down.
module btn_conditioner #(
    parameter int NUM_BTN      = 5,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic               CLK100MHZ,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int               RPT_MAX     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int               RPT_W       = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_V = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RATE_V  = RPT_W'(REPEAT_RATE);
`endif

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    logic [NUM_BTN-1:0] sync_q1;
    logic [NUM_BTN-1:0] sync_q2;

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             s;

        assign s = sync_q2[i];

`ifdef BTN_AUTOREPEAT_EN
        // rpt_first selects the long initial delay until the first repeat has fired
        logic [RPT_W-1:0] rpt_cnt;
        logic             rpt_first;
        logic [RPT_W-1:0] rpt_next;
        logic             rpt_fire;

        assign rpt_next = rpt_cnt + RPT_W'(1);
        assign rpt_fire = (rpt_next == (rpt_first ? RPT_DELAY_V : RPT_RATE_V));
`endif

        always_ff @(posedge CLK100MHZ or negedge reset_n) begin
            if (!reset_n) begin
                state     <= S_LOW;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
`endif
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
`endif
                if (!enable) begin
                    // pending transitions are abandoned so a full period is needed after re-enable
                    cnt <= '0;
                    if (state == S_RISE) begin
                        state <= S_LOW;
                    end else if (state == S_FALL) begin
                        state <= S_HIGH;
                    end
                end else begin
                    case (state)
                        S_LOW: begin
                            if (s) begin
                                state <= S_RISE;
                                cnt   <= CNT_ONE;
                            end else begin
                                cnt <= '0;
                            end
                        end
                        S_RISE: begin
                            if (!s) begin
                                state <= S_LOW;
                                cnt   <= '0;
                            end else if (cnt == CNT_MAX) begin
                                state   <= S_HIGH;
                                cnt     <= '0;
                                level_q <= 1'b1;
                                press_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                        S_HIGH: begin
                            if (!s) begin
                                state <= S_FALL;
                                cnt   <= CNT_ONE;
                            end else begin
                                cnt <= '0;
`ifdef BTN_AUTOREPEAT_EN
                                if (rpt_fire) begin
                                    press_q   <= 1'b1;
                                    rpt_cnt   <= '0;
                                    rpt_first <= 1'b0;
                                end else begin
                                    rpt_cnt   <= rpt_next;
                                    rpt_first <= rpt_first;
                                end
`endif
                            end
                        end
                        S_FALL: begin
                            if (s) begin
                                state <= S_HIGH;
                                cnt   <= '0;
                            end else if (cnt == CNT_MAX) begin
                                state     <= S_LOW;
                                cnt       <= '0;
                                level_q   <= 1'b0;
                                release_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                        default: begin
                            state <= S_LOW;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: expected strobes are queued with their cycle when stimulus is driven.
// Build with BTN_AUTOREPEAT_EN defined to also expect the auto-repeat press strobes.
`timescale 1ns/1ps
module tb_btn_conditioner;

    localparam int NB    = 5;
    localparam int DEB   = 8;
    localparam int RDLY  = 20;
    localparam int RRATE = 5;
    // input driven just after edge n reaches the FSM at edge n+3, so the strobe follows at edge n+3+DEB
    localparam int LAT   = DEB + 3;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          enable  = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    btn_conditioner #(
        .NUM_BTN      (NB),
        .DEBOUNCE_CYC (DEB),
        .REPEAT_DELAY (RDLY),
        .REPEAT_RATE  (RRATE)
    ) dut (
        .CLK100MHZ   (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        bit is_rel;
        int idx;
        int cyc;
    } event_t;

    event_t exp_q[$];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic expectEvent(input bit is_rel, input int idx, input int at);
        event_t e;
        e.is_rel = is_rel;
        e.idx    = idx;
        e.cyc    = at;
        exp_q.push_back(e);
    endtask

    task automatic matchEvent(input bit is_rel, input int idx);
        int found;
        found = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (found < 0 && exp_q[j].is_rel == is_rel && exp_q[j].idx == idx) found = j;
        end
        if (found >= 0) begin
            checkOutput($sformatf("%s_b%0d_cycle", is_rel ? "release" : "press", idx), cyc, exp_q[found].cyc);
            exp_q.delete(found);
        end else begin
            checkOutput($sformatf("spurious_%s_b%0d", is_rel ? "release" : "press", idx), 1, 0);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] raw, input int hold);
        btn_raw = raw;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    // strobes are sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < NB; i++) begin
                if (btn_press[i])   matchEvent(1'b0, i);
                if (btn_release[i]) matchEvent(1'b1, i);
            end
        end
    end

    initial begin
        int t;
        logic [NB-1:0] r;

        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset_level", int'(btn_level), 0);
        checkOutput("reset_press", int'(btn_press), 0);
        checkOutput("reset_release", int'(btn_release), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus('0, 5);

        t = cyc;
        expectEvent(1'b0, 1, t + LAT);
        applyStimulus(5'b00010, 20);
        checkOutput("clean_level_held", int'(btn_level), 5'b00010);
        applyStimulus(5'b00010, 20);
        t = cyc;
        expectEvent(1'b1, 1, t + LAT);
        applyStimulus(5'b00000, 20);
        checkOutput("clean_level_after", int'(btn_level), 0);
        checkOutput("clean_pending", exp_q.size(), 0);

        r = '0;
        for (int k = 0; k < 10; k++) begin
            r[0] = ~r[0];
            applyStimulus(r, 3);
        end
        t = cyc;
        expectEvent(1'b0, 0, t + LAT);
        applyStimulus(5'b00001, 20);
        checkOutput("bounce_level", int'(btn_level), 5'b00001);
        checkOutput("bounce_pending", exp_q.size(), 0);

        applyStimulus(5'b10001, 5);
        applyStimulus(5'b00001, 20);
        checkOutput("glitch_level", int'(btn_level), 5'b00001);

        enable = 1'b0;
        applyStimulus(5'b00101, 30);
        checkOutput("disabled_level", int'(btn_level), 5'b00001);
        t = cyc;
        enable = 1'b1;
        expectEvent(1'b0, 2, t + DEB + 1);
        applyStimulus(5'b00101, 20);
        checkOutput("enable_level", int'(btn_level), 5'b00101);
        checkOutput("enable_pending", exp_q.size(), 0);

        t = cyc;
        expectEvent(1'b0, 3, t + LAT);
`ifdef BTN_AUTOREPEAT_EN
        // repeats stop once the FSM sees the release, three edges after it is driven
        for (int p = t + LAT + RDLY; p < t + 60 + 3; p += RRATE) expectEvent(1'b0, 3, p);
`endif
        applyStimulus(5'b01101, 40);
        checkOutput("repeat_level_held", int'(btn_level), 5'b01101);
        applyStimulus(5'b01101, 20);
        expectEvent(1'b1, 3, cyc + LAT);
        applyStimulus(5'b00101, 20);
        checkOutput("repeat_level_after", int'(btn_level), 5'b00101);
        checkOutput("repeat_pending", exp_q.size(), 0);

        btn_raw = 5'b11111;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_level", int'(btn_level), 0);
        checkOutput("midrst_press", int'(btn_press), 0);
        checkOutput("midrst_release", int'(btn_release), 0);
        #2 reset_n = 1'b1;
        t = cyc;
        for (int i = 0; i < NB; i++) expectEvent(1'b0, i, t + LAT);
        applyStimulus(5'b11111, 20);
        checkOutput("held_rst_level", int'(btn_level), 5'b11111);
        t = cyc;
        for (int i = 0; i < NB; i++) expectEvent(1'b1, i, t + LAT);
        applyStimulus(5'b00000, 20);
        checkOutput("final_level", int'(btn_level), 0);
        checkOutput("final_pending", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
